// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] NOP_PC     = 32'h0000_0000;
  localparam logic [31:0] NOP_INS    = 32'h0000_0013;
  localparam logic        ChipStall  = 1'b1;
  localparam logic        StageClear = 1'b1;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall-cycle and flush-cycle performance counters for pipe_ctrl.
// Present only when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rdy,
  input  logic        i_stall_pc,
  input  logic        i_redirect_valid,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Free-running wrap-around event counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (i_stall_pc && i_rdy) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (i_redirect_valid) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Optional performance counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int ADDR_W        = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              id_load_use,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_redirect_pc,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              stall_id_ex,
  output logic              stall_ex_mem,
  output logic              stall_mem_wb,
  output logic              clear_if_id,
  output logic              clear_id_ex,
  output logic              clear_ex_mem,
  output logic              pc_redirect_valid,
  output logic [ADDR_W-1:0] pc_redirect,
  output logic              timeout_out
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(STALL_TIMEOUT - 1);

  state_e              r_state;
  state_e              w_next_state;
  logic                r_pend_valid;
  logic [ADDR_W-1:0]   r_pend_pc;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_timeout;
  logic                w_redir_take;
  logic [ADDR_W-1:0]   w_redir_pc;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: a frozen chip never changes state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN: begin
        if (rdy_in && mem_busy) w_next_state = MEM_WAIT;
        else                    w_next_state = RUN;
      end
      MEM_WAIT: begin
        if (rdy_in && !mem_busy) w_next_state = RUN;
        else                     w_next_state = MEM_WAIT;
      end
      default: w_next_state = RUN;
    endcase
  end

  // Deferred redirect, wait counter and sticky timeout
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= ADDR_W'(NOP_PC);
      r_wait_cnt   <= {CNT_W{1'b0}};
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (rdy_in && mem_busy) begin
            r_wait_cnt <= {CNT_W{1'b0}};
            if (ex_redirect) begin
              r_pend_valid <= 1'b1;
              r_pend_pc    <= ex_redirect_pc;
            end else begin
              r_pend_valid <= 1'b0;
            end
          end else begin
            r_pend_valid <= r_pend_valid;
          end
        end
        MEM_WAIT: begin
          if (!rdy_in) begin
            r_wait_cnt <= r_wait_cnt;
          end else if (mem_busy) begin
            if (r_wait_cnt != TMO) r_wait_cnt <= r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            else                   r_wait_cnt <= r_wait_cnt;
            if (r_wait_cnt >= TMO_M1) r_timeout <= 1'b1;
            else                      r_timeout <= r_timeout;
          end else begin
            r_wait_cnt   <= {CNT_W{1'b0}};
            r_pend_valid <= 1'b0;
          end
        end
        default: r_wait_cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Which redirect source is live: EX in RUN, the deferred one in MEM_WAIT
  always_comb begin
    w_redir_take = 1'b0;
    w_redir_pc   = ex_redirect_pc;
    case (r_state)
      RUN: begin
        w_redir_take = ex_redirect;
        w_redir_pc   = ex_redirect_pc;
      end
      MEM_WAIT: begin
        w_redir_take = r_pend_valid;
        w_redir_pc   = r_pend_pc;
      end
      default: w_redir_take = 1'b0;
    endcase
  end

  // Stall/clear/redirect outputs
  always_comb begin
    stall_pc          = 1'b0;
    stall_if_id       = 1'b0;
    stall_id_ex       = 1'b0;
    stall_ex_mem      = 1'b0;
    stall_mem_wb      = 1'b0;
    clear_if_id       = 1'b0;
    clear_id_ex       = 1'b0;
    clear_ex_mem      = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = {ADDR_W{1'b0}};
    if (!rst_in) begin
      clear_if_id  = StageClear;
      clear_id_ex  = StageClear;
      clear_ex_mem = StageClear;
    end else if (!rdy_in || mem_busy) begin
      stall_pc     = ChipStall;
      stall_if_id  = ChipStall;
      stall_id_ex  = ChipStall;
      stall_ex_mem = ChipStall;
      stall_mem_wb = ChipStall;
    end else if (w_redir_take) begin
      pc_redirect_valid = 1'b1;
      pc_redirect       = w_redir_pc;
      clear_if_id       = StageClear;
      clear_id_ex       = StageClear;
    end else if (id_load_use) begin
      stall_pc    = ChipStall;
      stall_if_id = ChipStall;
      clear_id_ex = StageClear;
    end else if (if_busy) begin
      stall_pc    = ChipStall;
      clear_if_id = StageClear;
    end else begin
      stall_pc = 1'b0;
    end
  end

  assign timeout_out = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_perf (
    .i_clk            (clk_in),
    .i_rst_n          (rst_in),
    .i_rdy            (rdy_in),
    .i_stall_pc       (stall_pc),
    .i_redirect_valid (pc_redirect_valid),
    .o_stall_cnt      (perf_stall_cnt),
    .o_flush_cnt      (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (STALL_TIMEOUT reduced to 8).
module tb_pipe_ctrl;

  localparam int ADDR_W = 32;

  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
  //  clear_if_id, clear_id_ex, clear_ex_mem, pc_redirect_valid}
  localparam logic [8:0] O_NONE  = 9'b00000_000_0;
  localparam logic [8:0] O_RST   = 9'b00000_111_0;
  localparam logic [8:0] O_STALL = 9'b11111_000_0;
  localparam logic [8:0] O_REDIR = 9'b00000_110_1;
  localparam logic [8:0] O_LDUSE = 9'b11000_010_0;
  localparam logic [8:0] O_IFBSY = 9'b10000_100_0;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, if_busy, mem_busy, id_load_use, ex_redirect;
  logic [ADDR_W-1:0] ex_redirect_pc;
  logic              stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic              clear_if_id, clear_id_ex, clear_ex_mem, pc_redirect_valid;
  logic [ADDR_W-1:0] pc_redirect;
  logic              timeout_out;
  logic [8:0]        obs;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.STALL_TIMEOUT(8), .ADDR_W(ADDR_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .if_busy(if_busy),
    .mem_busy(mem_busy), .id_load_use(id_load_use), .ex_redirect(ex_redirect),
    .ex_redirect_pc(ex_redirect_pc), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex), .clear_ex_mem(clear_ex_mem),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
    .timeout_out(timeout_out)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  assign obs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                clear_if_id, clear_id_ex, clear_ex_mem, pc_redirect_valid};

  task automatic idle_inputs();
    rdy_in = 1'b1; if_busy = 1'b0; mem_busy = 1'b0;
    id_load_use = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = 32'h0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    idle_inputs();
    @(negedge clk_in); #1;
    checks++;
    if (obs !== O_RST) begin errors++; $display("FAIL reset_outs obs=%b exp=%b", obs, O_RST); end
    checks++;
    if (timeout_out !== 1'b0 || pc_redirect !== 32'h0) begin
      errors++; $display("FAIL reset_tmo_pc tmo=%b pc=%h exp 0/0", timeout_out, pc_redirect);
    end
    @(negedge clk_in); rst_in = 1'b1; #1;
    checks++;
    if (obs !== O_NONE) begin errors++; $display("FAIL idle_after_reset obs=%b exp=%b", obs, O_NONE); end
    checks++;
    if (timeout_out !== 1'b0) begin errors++; $display("FAIL idle_tmo tmo=%b exp=0", timeout_out); end
  endtask

  task automatic test_load_use();
    @(negedge clk_in); id_load_use = 1'b1; #1;
    checks++;
    if (obs !== O_LDUSE) begin errors++; $display("FAIL load_use obs=%b exp=%b", obs, O_LDUSE); end
    @(negedge clk_in); id_load_use = 1'b0; #1;
    checks++;
    if (obs !== O_NONE) begin errors++; $display("FAIL load_use_after obs=%b exp=%b", obs, O_NONE); end
  endtask

  task automatic test_if_busy_rdy();
    @(negedge clk_in); if_busy = 1'b1; #1;
    checks++;
    if (obs !== O_IFBSY) begin errors++; $display("FAIL if_busy obs=%b exp=%b", obs, O_IFBSY); end
    @(negedge clk_in); rdy_in = 1'b0; ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0ABC; #1;
    checks++;
    if (obs !== O_STALL) begin errors++; $display("FAIL rdy_low_run obs=%b exp=%b", obs, O_STALL); end
    @(negedge clk_in); idle_inputs(); #1;
    checks++;
    if (obs !== O_NONE) begin errors++; $display("FAIL rdy_back obs=%b exp=%b", obs, O_NONE); end
  endtask

  task automatic test_redirect();
    @(negedge clk_in); ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_1000; id_load_use = 1'b1; #1;
    checks++;
    if (obs !== O_REDIR || pc_redirect !== 32'h0000_1000) begin
      errors++; $display("FAIL redirect obs=%b pc=%h exp=%b pc=00001000", obs, pc_redirect, O_REDIR);
    end
    @(negedge clk_in); idle_inputs(); #1;
    checks++;
    if (obs !== O_NONE) begin errors++; $display("FAIL redirect_after obs=%b exp=%b", obs, O_NONE); end
  endtask

  task automatic test_mem_redirect();
    @(negedge clk_in); mem_busy = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_2000;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin
        @(negedge clk_in); ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_3000;
      end
      #1;
      checks++;
      if (obs !== O_STALL) begin errors++; $display("FAIL memwait_stall c=%0d obs=%b exp=%b", c, obs, O_STALL); end
    end
    @(negedge clk_in); mem_busy = 1'b0; ex_redirect = 1'b0; #1;
    checks++;
    if (obs !== O_REDIR || pc_redirect !== 32'h0000_2000) begin
      errors++; $display("FAIL pend_redirect obs=%b pc=%h exp=%b pc=00002000", obs, pc_redirect, O_REDIR);
    end
    @(negedge clk_in); #1;
    checks++;
    if (obs !== O_NONE || timeout_out !== 1'b0) begin
      errors++; $display("FAIL pend_cleared obs=%b tmo=%b exp=%b tmo=0", obs, timeout_out, O_NONE);
    end
  endtask

  task automatic test_freeze_release();
    @(negedge clk_in); mem_busy = 1'b1; #1;
    @(negedge clk_in); mem_busy = 1'b0; rdy_in = 1'b0; #1;
    checks++;
    if (obs !== O_STALL) begin errors++; $display("FAIL memwait_frozen obs=%b exp=%b", obs, O_STALL); end
    @(negedge clk_in); rdy_in = 1'b1; id_load_use = 1'b1; #1;
    checks++;
    if (obs !== O_LDUSE) begin errors++; $display("FAIL release_load_use obs=%b exp=%b", obs, O_LDUSE); end
    @(negedge clk_in); idle_inputs(); if_busy = 1'b1; #1;
    checks++;
    if (obs !== O_IFBSY) begin errors++; $display("FAIL back_in_run obs=%b exp=%b", obs, O_IFBSY); end
    @(negedge clk_in); idle_inputs();
  endtask

  task automatic test_timeout();
    // cycle 1 is the RUN entry cycle; cycle c>1 is MEM_WAIT cycle c-1
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_in); mem_busy = 1'b1; #1;
      checks++;
      if (timeout_out !== (c >= 10)) begin
        errors++; $display("FAIL timeout c=%0d tmo=%b exp=%b", c, timeout_out, (c >= 10));
      end
    end
    @(negedge clk_in); mem_busy = 1'b0; #1;
    checks++;
    if (obs !== O_NONE || timeout_out !== 1'b1) begin
      errors++; $display("FAIL timeout_release obs=%b tmo=%b exp=%b tmo=1", obs, timeout_out, O_NONE);
    end
    @(negedge clk_in); #1;
    checks++;
    if (timeout_out !== 1'b1) begin errors++; $display("FAIL timeout_sticky tmo=%b exp=1", timeout_out); end
    @(negedge clk_in); rst_in = 1'b0; #1;
    checks++;
    if (timeout_out !== 1'b0) begin errors++; $display("FAIL timeout_reset tmo=%b exp=0", timeout_out); end
    @(negedge clk_in); rst_in = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk_in); mem_busy = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_4000; #1;
    @(negedge clk_in); ex_redirect = 1'b0; #1;
    checks++;
    if (obs !== O_STALL) begin errors++; $display("FAIL pre_reset_stall obs=%b exp=%b", obs, O_STALL); end
    @(negedge clk_in); rst_in = 1'b0; #1;
    checks++;
    if (obs !== O_RST) begin errors++; $display("FAIL mid_reset obs=%b exp=%b", obs, O_RST); end
    @(negedge clk_in); rst_in = 1'b1; mem_busy = 1'b0; #1;
    checks++;
    if (obs !== O_NONE || pc_redirect !== 32'h0) begin
      errors++; $display("FAIL no_pend_after_reset obs=%b pc=%h exp=%b pc=0", obs, pc_redirect, O_NONE);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_reset stall=%0d flush=%0d exp 0/0", perf_stall_cnt, perf_flush_cnt);
    end
    @(negedge clk_in); id_load_use = 1'b1;
    @(negedge clk_in); id_load_use = 1'b0; ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_5000;
    @(negedge clk_in); rdy_in = 1'b0; ex_redirect = 1'b0;
    @(negedge clk_in); idle_inputs(); #1;
    checks++;
    if (perf_stall_cnt !== 32'd1 || perf_flush_cnt !== 32'd1) begin
      errors++; $display("FAIL perf_count stall=%0d flush=%0d exp 1/1", perf_stall_cnt, perf_flush_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_if_busy_rdy();
    test_redirect();
    test_mem_redirect();
    test_freeze_release();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
